des_subkey_sequencer: RTL and testbench

DES_SUBKEY_SEQUENCER -- requirements
Module: des_subkey_sequencer

---
 rtl/des_pkg.sv | 7 +
 rtl/des_subkey_ram.sv | 27 ++
 rtl/des_subkey_sequencer.sv | 88 ++++++++
 tb/tb_des_subkey_sequencer.sv | 185 ++++++++++++++++++
 4 files changed

// File: rtl/des_pkg.sv
// des_pkg: shared types and widths for the DES subkey sequencer.
package des_pkg;
  localparam int DES_ROUNDS = 16;
  localparam int SUBKEY_W   = 48;
  localparam int KEY_W      = 64;
  typedef enum logic [1:0] {IDLE, ISSUE, CAPTURE, READY} seqState_t;
endpackage

// File: rtl/des_subkey_ram.sv
// des_subkey_ram: 16 x 48 round-key register file with a registered, gated read port.
module des_subkey_ram
  import des_pkg::*;
(
  input  logic                clk,
  input  logic                rst_n,
  input  logic                we,
  input  logic [3:0]          waddr,
  input  logic [SUBKEY_W-1:0] wdata,
  input  logic                re,
  input  logic [3:0]          raddr,
  output logic [SUBKEY_W-1:0] rdata,
  output logic                rvalid
);
  logic [SUBKEY_W-1:0] mem [DES_ROUNDS];
  always_ff @(posedge clk)
    if (we) mem[waddr] <= wdata;
  // Contents are never cleared; a gated read returns zero instead.
  always_ff @(posedge clk)
    if (!rst_n) begin
      rdata  <= '0;
      rvalid <= 1'b0;
    end else begin
      rvalid <= re;
      rdata  <= re ? mem[raddr] : '0;
    end
endmodule

// File: rtl/des_subkey_sequencer.sv
// des_subkey_sequencer: drives an external subkey generator to fill a 16-entry round-key table,
// then serves encrypt/decrypt-ordered reads. Define DES_SUBKEY_PARITY_CHK_EN for the key odd-parity check.
module des_subkey_sequencer
  import des_pkg::*;
#(
  parameter int GEN_LATENCY = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              key_valid,
  input  logic [1:KEY_W]    key_in,
  output logic              key_ready,
  output logic              gen_start,
  output logic [5:0]        gen_keyid,
  output logic [1:KEY_W]    gen_key,
  input  logic [1:SUBKEY_W] gen_branchkey,
  input  logic              decrypt,
  input  logic [4:0]        rd_idx,
  output logic [SUBKEY_W-1:0] rd_key,
  output logic              rd_valid,
  output logic              table_ready,
  output logic              parity_err
);
  seqState_t state, nextState;
  logic [4:0] counter;
  logic [3:0] latCnt;
  logic [4:0] rdSel;
  logic accept, latDone, lastRound, rdInRange;
  assign accept    = key_valid && key_ready;
  assign latDone   = latCnt == 4'(GEN_LATENCY - 1);
  assign lastRound = counter == 5'(DES_ROUNDS);
  assign gen_keyid = {1'b0, counter};
  assign rdInRange = rd_idx >= 5'd1 && rd_idx <= 5'(DES_ROUNDS);
  assign rdSel     = decrypt ? 5'(DES_ROUNDS + 1) - rd_idx : rd_idx;
  always_ff @(posedge clk)
    if (!rst_n) state <= IDLE;
    else state <= nextState;
  always_comb begin
    nextState = state;
    if (accept) nextState = ISSUE;
    else if (state == ISSUE && latDone) nextState = CAPTURE;
    else if (state == CAPTURE) nextState = lastRound ? READY : ISSUE;
  end
  always_comb begin
    key_ready = state == IDLE || state == READY;
    gen_start = state == ISSUE || state == CAPTURE;
  end
  always_ff @(posedge clk)
    if (!rst_n) begin
      counter     <= 5'd1;
      latCnt      <= '0;
      gen_key     <= '0;
      table_ready <= 1'b0;
    end else if (accept) begin
      counter     <= 5'd1;
      latCnt      <= '0;
      gen_key     <= key_in;
      table_ready <= 1'b0;
    end else if (state == ISSUE) begin
      latCnt <= latDone ? '0 : latCnt + 4'd1;
    end else if (state == CAPTURE) begin
      if (lastRound) table_ready <= 1'b1;
      else counter <= counter + 5'd1;
    end
`ifdef DES_SUBKEY_PARITY_CHK_EN
  logic parityBad;
  always_comb begin
    parityBad = 1'b0;
    for (int b = 0; b < 8; b++) parityBad = parityBad | ~^key_in[8*b+1 +: 8];
  end
  always_ff @(posedge clk)
    if (!rst_n) parity_err <= 1'b0;
    else if (accept) parity_err <= parityBad;
`else
  assign parity_err = 1'b0;
`endif
  des_subkey_ram ram (
    .clk    (clk),
    .rst_n  (rst_n),
    .we     (state == CAPTURE),
    .waddr  (4'(counter - 5'd1)),
    .wdata  (gen_branchkey),
    .re     (table_ready && rdInRange),
    .raddr  (4'(rdSel - 5'd1)),
    .rdata  (rd_key),
    .rvalid (rd_valid)
  );
endmodule

// File: tb/tb_des_subkey_sequencer.sv
// tb_des_subkey_sequencer: directed bench with a latency-accurate DES key-schedule generator model.
module tb_des_subkey_sequencer;
  localparam int LAT = 5;
  localparam int PC1 [56] = '{57,49,41,33,25,17,9, 1,58,50,42,34,26,18,
                              10,2,59,51,43,35,27, 19,11,3,60,52,44,36,
                              63,55,47,39,31,23,15, 7,62,54,46,38,30,22,
                              14,6,61,53,45,37,29, 21,13,5,28,20,12,4};
  localparam int PC2 [48] = '{14,17,11,24,1,5, 3,28,15,6,21,10,
                              23,19,12,4,26,8, 16,7,27,20,13,2,
                              41,52,31,37,47,55, 30,40,51,45,33,48,
                              44,49,39,56,34,53, 46,42,50,36,29,32};
  localparam int SH [16] = '{1,1,2,2,2,2,2,2,1,2,2,2,2,2,2,1};

  logic clk = 1'b0, rst_n = 1'b0, key_valid = 1'b0, decrypt = 1'b0;
  logic [1:64] key_in = '0;
  logic [4:0] rd_idx = '0;
  logic key_ready, gen_start, rd_valid, table_ready, parity_err;
  logic [5:0] gen_keyid;
  logic [1:64] gen_key;
  logic [1:48] gen_branchkey;
  logic [47:0] rd_key;
  logic [1:48] pipe [LAT];
  int errors = 0, checks = 0;
  logic expP;

  always #5 clk = ~clk;

  des_subkey_sequencer #(.GEN_LATENCY(LAT)) dut (
    .clk(clk), .rst_n(rst_n), .key_valid(key_valid), .key_in(key_in), .key_ready(key_ready),
    .gen_start(gen_start), .gen_keyid(gen_keyid), .gen_key(gen_key), .gen_branchkey(gen_branchkey),
    .decrypt(decrypt), .rd_idx(rd_idx), .rd_key(rd_key), .rd_valid(rd_valid),
    .table_ready(table_ready), .parity_err(parity_err)
  );

  function automatic logic [1:48] desSubkey(input logic [1:64] k, input int r);
    logic [1:56] cd;
    logic [1:28] c, d;
    logic [1:48] o;
    int rr;
    rr = r > 16 ? 16 : r;
    for (int i = 0; i < 56; i++) cd[i+1] = k[PC1[i]];
    c = cd[1:28];
    d = cd[29:56];
    for (int j = 0; j < rr; j++)
      for (int s = 0; s < SH[j]; s++) begin
        c = {c[2:28], c[1]};
        d = {d[2:28], d[1]};
      end
    cd = {c, d};
    for (int i = 0; i < 48; i++) o[i+1] = cd[PC2[i]];
    return o;
  endfunction

  // Generator model: result for the presented keyid appears LAT cycles later.
  always @(posedge clk) begin
    pipe[0] <= desSubkey(gen_key, int'(gen_keyid));
    for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
  end
  assign gen_branchkey = pipe[LAT-1];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic readCheck(input string tag, input int idx, input logic dec,
                           input logic [47:0] expKey, input logic expValid);
    rd_idx = 5'(idx);
    decrypt = dec;
    tick;
    check({tag, "_valid"}, rd_valid, expValid);
    check({tag, "_key"}, rd_key, expKey);
  endtask

  task automatic loadKey(input logic [63:0] key, input int pulseRound, output int cycles);
    bit pulsed = 0;
    key_in = key;
    key_valid = 1'b1;
    tick;
    key_valid = 1'b0;
    check("accept_gen_start", gen_start, 1);
    check("accept_keyid", gen_keyid, 1);
    cycles = 0;
    while (!table_ready && cycles < 300) begin
      if (pulseRound > 0 && !pulsed && gen_start && gen_keyid == 6'(pulseRound)) begin
        key_in = ~key;
        key_valid = 1'b1;
        check("busy_key_ready", key_ready, 0);
        pulsed = 1;
      end
      tick;
      cycles++;
      key_valid = 1'b0;
      if (cycles == 1) check("stale_read_hidden", rd_valid, 0);
    end
    key_in = key;
    check("load_cycles", cycles, 96);
    check("load_gen_key", gen_key, key);
    check("ready_gen_start", gen_start, 0);
    check("ready_key_ready", key_ready, 1);
    check("ready_keyid_hold", gen_keyid, 16);
  endtask

  initial begin
    int n;
    logic [63:0] keyA, keyB, keyC;
    keyA = 64'h133457799BBCDFF1;
    keyB = 64'h0101010101010101;
    keyC = 64'h0001010101010101;
`ifdef DES_SUBKEY_PARITY_CHK_EN
    expP = 1'b1;
`else
    expP = 1'b0;
`endif
    tick;
    tick;
    check("rst_key_ready", key_ready, 1);
    check("rst_gen_start", gen_start, 0);
    check("rst_keyid", gen_keyid, 1);
    check("rst_gen_key", gen_key, 0);
    check("rst_rd_valid", rd_valid, 0);
    check("rst_rd_key", rd_key, 0);
    check("rst_table_ready", table_ready, 0);
    check("rst_parity", parity_err, 0);
    rst_n = 1'b1;
    readCheck("pre_table_idx5", 5, 0, 48'h0, 0);

    loadKey(keyA, 0, n);
    check("parity_keyA", parity_err, 0);
    readCheck("enc_k1", 1, 0, 48'h1B02EFFC7072, 1);
    readCheck("dec_idx1", 1, 1, 48'hCB3D8B0E17F5, 1);
    readCheck("enc_k16", 16, 0, 48'hCB3D8B0E17F5, 1);
    readCheck("dec_idx16", 16, 1, 48'h1B02EFFC7072, 1);
    readCheck("idx0", 0, 0, 48'h0, 0);
    readCheck("idx17", 17, 0, 48'h0, 0);
    readCheck("idx0_dec", 0, 1, 48'h0, 0);
    for (int i = 1; i <= 16; i++) begin
      readCheck($sformatf("A_enc%0d", i), i, 0, desSubkey(keyA, i), 1);
      readCheck($sformatf("A_dec%0d", i), i, 1, desSubkey(keyA, 17 - i), 1);
    end

    rd_idx = 5'd1;
    decrypt = 1'b0;
    loadKey(keyB, 7, n);
    check("parity_keyB", parity_err, 0);
    for (int i = 1; i <= 16; i++)
      readCheck($sformatf("B_enc%0d", i), i, 0, desSubkey(keyB, i), 1);

    key_in = keyC;
    key_valid = 1'b1;
    tick;
    key_valid = 1'b0;
    check("parity_keyC", parity_err, expP);
    n = 0;
    while (gen_keyid != 6'd9 && n < 200) begin
      tick;
      n++;
    end
    check("reach_round9", gen_keyid, 9);
    rst_n = 1'b0;
    tick;
    rst_n = 1'b1;
    check("midrst_key_ready", key_ready, 1);
    check("midrst_gen_start", gen_start, 0);
    check("midrst_table_ready", table_ready, 0);
    check("midrst_keyid", gen_keyid, 1);
    check("midrst_parity", parity_err, 0);
    readCheck("midrst_read", 3, 0, 48'h0, 0);
    loadKey(keyC, 0, n);
    check("parity_keyC_reload", parity_err, expP);
    for (int i = 1; i <= 16; i++)
      readCheck($sformatf("C_dec%0d", i), i, 1, desSubkey(keyC, 17 - i), 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
